snoop_event_capture: RTL and testbench

- Sits directly downstream of the SNES bus snooper, in the system clock domain.
- Takes the snooper's 16-bit controller word and frame-complete flag, which are asynchronous to clk.
- Detects each completed frame and keeps a last-seen snapshot.
- When the controller word changes, it queues an event (frame number, new word, pressed mask, released mask) in a small FIFO. A valid/ready interface drains the FIFO toward the host-side logic.

---
 rtl/snooper_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 36 +++
 rtl/snoop_event_capture.sv | 68 ++++++
 tb/tb_snoop_event_capture.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/snooper_pkg.sv
// snooper_pkg: shared SNES controller widths, button bit positions and the captured-event layout
package snooper_pkg;
  localparam int SNES_W = 16;
  localparam int FRAME_W = 16;
  localparam int BTN_B = 0;
  localparam int BTN_Y = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A = 8;
  localparam int BTN_X = 9;
  localparam int BTN_L = 10;
  localparam int BTN_R = 11;
  localparam logic [SNES_W-1:0] SNES_RELEASED = 16'hFFFF;
  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [SNES_W-1:0]  state;
    logic [SNES_W-1:0]  pressed;
    logic [SNES_W-1:0]  released;
  } snoop_event_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with valid/ready on both sides; push_ready also admits a push into a full FIFO when a pop happens in the same cycle
// ports: clk, reset (async, active-high), push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic full, do_push, do_pop;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_valid = wptr != rptr;
  assign do_pop = pop_valid & pop_ready;
  assign push_ready = ~full | do_pop;
  assign do_push = push_valid & push_ready;
  assign pop_data = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(do_push);
      rptr <= rptr + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/snoop_event_capture.sv
// snoop_event_capture: synchronizes the snooper frame flag, snapshots each frame and queues an event whenever the controller word changes
// ports: clk, reset (async, active-high), snoop_state/snoop_valid from the snooper,
//        out_valid/out_ready/out_state/out_frame/out_pressed/out_released event stream, frame_count, sticky overflow
module snoop_event_capture
  import snooper_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        snoop_state,
  input  logic               snoop_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_state,
  output logic [FRAME_W-1:0] out_frame,
  output logic [15:0]        out_pressed,
  output logic [15:0]        out_released,
  output logic [FRAME_W-1:0] frame_count,
  output logic               overflow
);
  localparam int EW = FRAME_W + 3 * SNES_W;
  logic v1, v2, v3, frame_tick, cap_vld, first_frame, change, push_ready;
  logic [SNES_W-1:0] cap, prev;
  logic [FRAME_W-1:0] cap_frame;
  logic [EW-1:0] head;
  always_ff @(posedge clk or posedge reset)
    if (reset) {v3, v2, v1} <= '0;
    else {v3, v2, v1} <= {v2, v1, snoop_valid};
  // snoop_state is only sampled here, after the flag has crossed two flops, so the word has long settled
  assign frame_tick = v2 & ~v3;
  assign change = cap_vld & ((cap != prev) | first_frame);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cap <= '0;
      cap_frame <= '0;
      cap_vld <= 1'b0;
      frame_count <= '0;
      prev <= SNES_RELEASED;
      first_frame <= 1'b1;
      overflow <= 1'b0;
    end else begin
      cap_vld <= frame_tick;
      if (frame_tick) begin
        cap <= snoop_state;
        cap_frame <= frame_count;
        frame_count <= frame_count + 1'b1;
      end
      // prev follows every capture, even a dropped one, so masks stay relative to the last seen frame
      if (cap_vld) begin
        prev <= cap;
        first_frame <= 1'b0;
      end
      if (change & ~push_ready) overflow <= 1'b1;
    end
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_valid(change),
    .push_ready(push_ready),
    .push_data ({cap_frame, cap, prev & ~cap, ~prev & cap}),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (head)
  );
  assign {out_frame, out_state, out_pressed, out_released} = out_valid ? head : '0;
endmodule

// File: tb/tb_snoop_event_capture.sv
// tb_snoop_event_capture: scoreboard bench for snoop_event_capture with directed frames
module tb_snoop_event_capture;
  import snooper_pkg::*;
  logic clk = 0, reset = 1, snoop_valid = 0, out_ready = 0;
  logic [15:0] snoop_state = 16'hFFFF;
  logic out_valid, overflow;
  logic [15:0] out_state, out_pressed, out_released, out_frame, frame_count;
  int n_total = 0, n_pass = 0;
  snoop_event_t exp_q[$];
  logic [15:0] m_prev = 16'hFFFF, m_count = 0;
  bit m_first = 1;

  snoop_event_capture #(.FIFO_DEPTH(8), .FRAME_W(16)) dut (
    .clk(clk), .reset(reset), .snoop_state(snoop_state), .snoop_valid(snoop_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_frame(out_frame),
    .out_pressed(out_pressed), .out_released(out_released), .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0)
        $display("FAIL event: unexpected event frame=%0h state=%0h", out_frame, out_state);
      else begin
        snoop_event_t e;
        e = exp_q.pop_front();
        if ({out_frame, out_state, out_pressed, out_released} === e) n_pass++;
        else $display("FAIL event: got frame=%0h state=%0h pressed=%0h released=%0h expected frame=%0h state=%0h pressed=%0h released=%0h",
                      out_frame, out_state, out_pressed, out_released, e.frame, e.state, e.pressed, e.released);
      end
    end

  task automatic model_reset();
    exp_q.delete();
    m_prev = 16'hFFFF;
    m_count = 0;
    m_first = 1;
  endtask

  // sim = raise out_ready for exactly the push cycle so a full FIFO pops and pushes together
  task automatic frame(input logic [15:0] s, input bit sim = 0);
    if (m_first || s != m_prev) begin
      if (exp_q.size() < 8 || sim || out_ready)
        exp_q.push_back('{frame: m_count, state: s, pressed: m_prev & ~s, released: ~m_prev & s});
    end
    m_prev = s;
    m_first = 0;
    m_count++;
    snoop_state = s;
    repeat (3) @(posedge clk);
    #1 snoop_valid = 1;
    if (sim) begin
      int n = 0;
      while (!dut.cap_vld && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      if (n >= 20) chk("cap_timeout", 1, 0);
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      repeat (2) @(posedge clk);
    end else repeat (4) @(posedge clk);
    #1 snoop_valid = 0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (2) @(posedge clk);
    #1 chk({name, "_left"}, 64'(exp_q.size()), 0);
    chk({name, "_valid"}, out_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_state", out_state, 0);
    out_ready = 1;
    frame(16'hFFFF);
    chk("count1", frame_count, 1);
    frame(16'hFFFE);
    frame(16'hFFFE);
    chk("count3", frame_count, 3);
    frame(16'hFEFF);
    drain("basic");
    chk("mask_a", 64'(16'h0001 << BTN_A), 16'h0100);
    out_ready = 0;
    for (int i = 0; i < 8; i++) frame(i[0] ? 16'hFFFF : 16'hFFFE);
    chk("full_valid", out_valid, 1);
    chk("full_head", out_frame, 4);
    frame(16'hFFFE, 1);
    chk("sim_ovf", overflow, 0);
    chk("sim_head", out_frame, 5);
    drain("sim");
    chk("sim_ovf2", overflow, 0);
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 10; i++) frame(i[0] ? 16'hFFFF : 16'hFFFE);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", frame_count, 10);
    chk("ovf_head", out_frame, 0);
    chk("ovf_pressed", out_pressed, 64'(16'h0001 << BTN_B));
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) frame(i[0] ? 16'hFFFF : 16'hFFFE);
    chk("mid_valid_before", out_valid, 1);
    reset = 1;
    #1 chk("mid_valid", out_valid, 0);
    chk("mid_count", frame_count, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    out_ready = 1;
    frame(16'hFFFF);
    drain("mid");
    chk("mid_count1", frame_count, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
